// File: rtl/fir_macn_ctrl.sv
// N-lane FIR multiply-accumulate controller: sweeps coefficient/sample RAMs LANES taps per cycle,
// reduces lanes through a registered adder tree, rounds half-to-even. Optional FIR_SAT_EN enables output saturation.
module fir_macn_ctrl #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 18,
  parameter int unsigned CW    = 36,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12,
  parameter int unsigned FRAC  = 35,
  parameter int unsigned OW    = 18
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  datain_ready,
  input  logic [AW-1:0]         data_base,
  input  logic [LANES*DW-1:0]   datain,
  input  logic [LANES*CW-1:0]   coefs_in,
  output logic [AW-1:0]         addr_data,
  output logic [AW-1:0]         addr_coefs,
  output logic [OW-1:0]         dataout,
  output logic                  dataout_ready,
  output logic                  busy,
  output logic                  sample_dropped,
  output logic                  overflow
);

  localparam int unsigned TREE       = $clog2(LANES);
  localparam int unsigned PW         = DW + CW;
  localparam int unsigned ACCW       = PW + $clog2(DEPTH);
  localparam int unsigned SW         = ACCW + TREE;
  localparam int unsigned RW         = ((SW - FRAC + 1) > (OW + 1)) ? (SW - FRAC + 1) : (OW + 1);
  localparam int unsigned DRAIN_LAST = 3 + TREE;
  localparam int unsigned CNTW       = $clog2(DRAIN_LAST + 1);

  localparam logic [AW-1:0] LAST_K   = AW'(DEPTH - 1);
  localparam logic [SW-1:0] LOW_MASK = (SW'(1) << (FRAC - 1)) - SW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [AW-1:0]   addr_data_nxt, addr_coefs_nxt;
  logic [OW-1:0]   dataout_nxt;
  logic            ready_nxt, busy_nxt, dropped_nxt, ovf_nxt;
  logic            start_c;

  logic signed [DW-1:0]   op_d [LANES];
  logic signed [CW-1:0]   op_c [LANES];
  logic signed [PW-1:0]   prod [LANES];
  logic signed [ACCW-1:0] acc  [LANES];
  logic                   v_mem, v_op, v_prod;

  logic signed [SW-1:0] sum_c;
  logic signed [RW-1:0] shifted_c, rounded_c;
  logic                 round_up_c;
  logic [OW-1:0]        result_c;
  logic                 clip_c;

  // Per-lane operand, product and accumulator pipeline; valid flags track memory latency
  always_ff @(posedge clock) begin
    if (reset) begin
      v_mem  <= 1'b0;
      v_op   <= 1'b0;
      v_prod <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        op_d[i] <= '0;
        op_c[i] <= '0;
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      v_mem  <= (state == RUN);
      v_op   <= v_mem;
      v_prod <= v_op;
      for (int i = 0; i < LANES; i++) begin
        op_d[i] <= datain[(LANES-1-i)*DW +: DW];
        op_c[i] <= coefs_in[(LANES-1-i)*CW +: CW];
        prod[i] <= PW'(op_d[i]) * PW'(op_c[i]);
        if (start_c) begin
          acc[i] <= '0;
        end else if (v_prod) begin
          acc[i] <= acc[i] + ACCW'(prod[i]);
        end
      end
    end
  end

  // Registered pairwise adder tree; stage 0 is the accumulators themselves
  for (genvar s = 0; s <= TREE; s++) begin : g_stage
    logic signed [SW-1:0] node [LANES >> s];
    if (s == 0) begin : g_leaf
      for (genvar j = 0; j < LANES; j++) begin : g_j
        assign node[j] = SW'(acc[j]);
      end
    end else begin : g_add
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int j = 0; j < (LANES >> s); j++) begin
            node[j] <= '0;
          end
        end else begin
          for (int j = 0; j < (LANES >> s); j++) begin
            node[j] <= g_stage[s-1].node[2*j] + g_stage[s-1].node[2*j+1];
          end
        end
      end
    end
  end

  assign sum_c = g_stage[TREE].node[0];

`ifdef FIR_SAT_EN
  localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;
`else
  logic unused_hi_c;
  assign unused_hi_c = ^rounded_c[RW-1:OW];
`endif

  // Round half to even at bit FRAC, then wrap or clip to OW bits
  always_comb begin
    round_up_c = sum_c[FRAC-1] & ((|(sum_c & LOW_MASK)) | sum_c[FRAC]);
    shifted_c  = RW'(sum_c >>> FRAC);
    rounded_c  = shifted_c + RW'(round_up_c);
    result_c   = rounded_c[OW-1:0];
    clip_c     = 1'b0;
`ifdef FIR_SAT_EN
    if (rounded_c > OUT_MAX) begin
      result_c = OUT_MAX[OW-1:0];
      clip_c   = 1'b1;
    end else if (rounded_c < OUT_MIN) begin
      result_c = OUT_MIN[OW-1:0];
      clip_c   = 1'b1;
    end
`endif
  end

  // Control state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_data      <= '0;
      addr_coefs     <= '0;
      dataout        <= '0;
      dataout_ready  <= 1'b0;
      busy           <= 1'b0;
      sample_dropped <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      addr_data      <= addr_data_nxt;
      addr_coefs     <= addr_coefs_nxt;
      dataout        <= dataout_nxt;
      dataout_ready  <= ready_nxt;
      busy           <= busy_nxt;
      sample_dropped <= dropped_nxt;
      overflow       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    addr_data_nxt  = addr_data;
    addr_coefs_nxt = addr_coefs;
    dataout_nxt    = dataout;
    ready_nxt      = 1'b0;
    busy_nxt       = busy;
    dropped_nxt    = datain_ready & busy;
    ovf_nxt        = 1'b0;
    start_c        = 1'b0;
    case (state)
      IDLE: begin
        if (datain_ready) begin
          start_c        = 1'b1;
          state_nxt      = RUN;
          addr_coefs_nxt = '0;
          addr_data_nxt  = data_base;
          busy_nxt       = 1'b1;
        end
      end
      RUN: begin
        if (addr_coefs == LAST_K) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          addr_coefs_nxt = addr_coefs + AW'(1);
          addr_data_nxt  = addr_data + AW'(1);
        end
      end
      DRAIN: begin
        // Last drain cycle is when the tree output holds the final sum
        if (cnt == CNTW'(DRAIN_LAST)) begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          ready_nxt   = 1'b1;
          dataout_nxt = result_c;
          ovf_nxt     = clip_c;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
